// File: rtl/add_slice_sequencer.sv
// Multi-cycle wide adder: drives one external NUMBITS-wide adder slice,
// least-significant slice first, keeping the inter-slice carry in a register.
module add_slice_sequencer #(
   parameter int NUMBITS   = 4,
   parameter int NUMSLICES = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUMBITS*NUMSLICES-1:0]   a,
   input  logic [NUMBITS*NUMSLICES-1:0]   b,
   input  logic                           c_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUMBITS*NUMSLICES-1:0]   sum,
   output logic                           c_out,
   output logic                           busy,
   output logic [15:0]                    ops_done,
   output logic [NUMBITS-1:0]             slice_a,
   output logic [NUMBITS-1:0]             slice_b,
   output logic                           slice_cin,
   input  logic [NUMBITS-1:0]             slice_s,
   input  logic                           slice_cout
);

   localparam int W    = NUMBITS * NUMSLICES;
   localparam int IDXW = (NUMSLICES > 1) ? $clog2(NUMSLICES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMSLICES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [W-1:0]      sum_q, sum_d;
   logic              c_out_q, c_out_d;
   logic              carry_q, carry_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [15:0]       ops_done_q, ops_done_d;

   logic [NUMBITS-1:0] sel_a_s;
   logic [NUMBITS-1:0] sel_b_s;
   logic               in_ready_s;
   logic               out_valid_s;
   logic               busy_s;
   logic [NUMBITS-1:0] slice_a_s;
   logic [NUMBITS-1:0] slice_b_s;
   logic               slice_cin_s;

   // Operand slice selected by idx; an AND-OR mux stays in range for any NUMSLICES.
   always_comb begin
      sel_a_s = '0;
      sel_b_s = '0;
      for (int k = 0; k < NUMSLICES; k++) begin
         sel_a_s = sel_a_s | (a_q[k*NUMBITS +: NUMBITS] & {NUMBITS{idx_q == IDXW'(k)}});
         sel_b_s = sel_b_s | (b_q[k*NUMBITS +: NUMBITS] & {NUMBITS{idx_q == IDXW'(k)}});
      end
   end

   // Handshake, status and adder-facing outputs decoded from the state register.
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      busy_s      = 1'b0;
      slice_a_s   = '0;
      slice_b_s   = '0;
      slice_cin_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_s = 1'b1;
         end
         ST_RUN: begin
            busy_s      = 1'b1;
            slice_a_s   = sel_a_s;
            slice_b_s   = sel_b_s;
            slice_cin_s = carry_q;
         end
         ST_DONE: begin
            busy_s      = 1'b1;
            out_valid_s = 1'b1;
         end
         default: begin
            in_ready_s = 1'b0;
         end
      endcase
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      c_out_d    = c_out_q;
      carry_d    = carry_q;
      idx_d      = idx_q;
      ops_done_d = ops_done_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = c_in;
               idx_d   = '0;
               sum_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            for (int k = 0; k < NUMSLICES; k++) begin
               sum_d[k*NUMBITS +: NUMBITS] = (idx_q == IDXW'(k)) ? slice_s
                                                                 : sum_q[k*NUMBITS +: NUMBITS];
            end
            carry_d = slice_cout;
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               c_out_d = slice_cout;
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            // New operands are deliberately not taken here, even on the release cycle.
            if (out_ready) begin
               ops_done_d = ops_done_q + 16'd1;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         c_out_q    <= 1'b0;
         carry_q    <= 1'b0;
         idx_q      <= '0;
         ops_done_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sum_q      <= sum_d;
         c_out_q    <= c_out_d;
         carry_q    <= carry_d;
         idx_q      <= idx_d;
         ops_done_q <= ops_done_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign busy      = busy_s;
   assign slice_a   = slice_a_s;
   assign slice_b   = slice_b_s;
   assign slice_cin = slice_cin_s;
   assign sum       = sum_q;
   assign c_out     = c_out_q;
   assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_add_slice_sequencer.sv
// Bench for add_slice_sequencer: models the external adder slice and checks
// results against plain a+b+c_in arithmetic.
module tb_add_slice_sequencer;

   localparam int NB = 4;
   localparam int NS = 4;
   localparam int W  = NB * NS;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          c_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          c_out;
   logic          busy;
   logic [15:0]   ops_done;
   logic [NB-1:0] slice_a;
   logic [NB-1:0] slice_b;
   logic          slice_cin;
   logic [NB-1:0] slice_s;
   logic          slice_cout;

   int checks;
   int errors;

   add_slice_sequencer #(.NUMBITS(NB), .NUMSLICES(NS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out), .busy(busy), .ops_done(ops_done),
      .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
      .slice_s(slice_s), .slice_cout(slice_cout)
   );

   // External carry-lookahead slice, behaviourally
   assign {slice_cout, slice_s} = (NB+1)'(slice_a) + (NB+1)'(slice_b) + (NB+1)'(slice_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++; $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100", {in_ready, out_valid, busy});
      end
      checks++;
      if (sum !== 16'h0000 || c_out !== 1'b0 || ops_done !== 16'd0) begin
         errors++; $display("FAIL reset_regs: got sum=%h c_out=%b ops=%0d expected 0000 0 0", sum, c_out, ops_done);
      end
      checks++;
      if ({slice_a, slice_b, slice_cin} !== 9'd0) begin
         errors++; $display("FAIL reset_slice: got %h expected 000", {slice_a, slice_b, slice_cin});
      end
      rst_n = 1'b1;
      tick();
   endtask

   // Launch one operation from IDLE; returns in cycle 1 (first RUN cycle).
   task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
      a = ta; b = tb; c_in = tc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_basic();
      logic [15:0] ops_before;
      ops_before = ops_done;
      launch(16'h00FF, 16'h0001, 1'b0);
      for (int cyc = 1; cyc <= NS; cyc++) begin
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_run_c%0d: got vld=%b busy=%b expected 0 1", cyc, out_valid, busy);
         end
         tick();
      end
      checks++;
      if (out_valid !== 1'b1 || sum !== 16'h0100 || c_out !== 1'b0) begin
         errors++; $display("FAIL basic_result: got vld=%b sum=%h c=%b expected 1 0100 0", out_valid, sum, c_out);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || ops_done !== ops_before + 16'd1) begin
         errors++; $display("FAIL basic_release: got rdy=%b ops=%0d expected 1 %0d", in_ready, ops_done, ops_before + 16'd1);
      end
   endtask

   task automatic test_carry_ripple();
      launch(16'hFFFF, 16'h0000, 1'b1);
      for (int cyc = 1; cyc <= NS; cyc++) begin
         checks++;
         if (slice_cin !== 1'b1) begin
            errors++; $display("FAIL ripple_cin_c%0d: got %b expected 1", cyc, slice_cin);
         end
         tick();
      end
      checks++;
      if (out_valid !== 1'b1 || sum !== 16'h0000 || c_out !== 1'b1) begin
         errors++; $display("FAIL ripple_result: got vld=%b sum=%h c=%b expected 1 0000 1", out_valid, sum, c_out);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_order_backpressure();
      logic [W-1:0] opa;
      logic [NB-1:0] exp_nib;
      opa = 16'h1234;
      launch(opa, 16'h0000, 1'b0);
      for (int cyc = 1; cyc <= NS; cyc++) begin
         exp_nib = NB'(opa >> ((cyc - 1) * NB));
         checks++;
         if (slice_a !== exp_nib) begin
            errors++; $display("FAIL order_slice_a_c%0d: got %h expected %h", cyc, slice_a, exp_nib);
         end
         tick();
      end
      for (int h = 0; h < 3; h++) begin
         in_valid = 1'b1; a = 16'hABCD; b = 16'h1111; c_in = 1'b1;
         checks++;
         if (out_valid !== 1'b1 || sum !== 16'h1234 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold_%0d: got vld=%b sum=%h rdy=%b expected 1 1234 0", h, out_valid, sum, in_ready);
         end
         tick();
      end
      // in_valid still high on the release edge; DONE must not accept it
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || sum !== 16'h1234) begin
         errors++; $display("FAIL hold_release: got rdy=%b busy=%b sum=%h expected 1 0 1234", in_ready, busy, sum);
      end
   endtask

   task automatic test_reset_mid_run();
      logic seen_valid;
      launch(16'h5555, 16'h3333, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || ops_done !== 16'd0 || slice_a !== 4'h0) begin
         errors++; $display("FAIL midreset_abort: got rdy/vld/busy=%b ops=%0d sa=%h expected 100 0 0",
                            {in_ready, out_valid, busy}, ops_done, slice_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid !== 1'b0) seen_valid = 1'b1;
      end
      checks++;
      if (seen_valid !== 1'b0 || ops_done !== 16'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_after: got seen_vld=%b ops=%0d rdy=%b expected 0 0 1", seen_valid, ops_done, in_ready);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   expv;
      int           lat, low, hold;
      for (int n = 0; n < 200; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(0, 1));
         expv = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
         launch(ra, rb, rc);
         lat = 1; low = 0;
         while (out_valid !== 1'b1 && lat < 20) begin
            if (in_ready === 1'b0) low++;
            in_valid = 1'($urandom_range(0, 1)); a = W'($urandom); b = W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
         end
         out_ready = 1'b0;
         checks++;
         if (lat != NS + 1) begin
            errors++; $display("FAIL rand_latency_%0d: got %0d expected %0d", n, lat, NS + 1);
         end
         hold = $urandom_range(0, 3);
         for (int h = 0; h < hold; h++) begin
            if (in_ready === 1'b0) low++;
            tick();
         end
         checks++;
         if (out_valid !== 1'b1 || {c_out, sum} !== expv) begin
            errors++; $display("FAIL rand_result_%0d: got vld=%b %h expected 1 %h", n, out_valid, {c_out, sum}, expv);
         end
         if (in_ready === 1'b0) low++;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         in_valid = 1'b0;
         checks++;
         if (in_ready !== 1'b1 || low != NS + 1 + hold) begin
            errors++; $display("FAIL rand_ready_%0d: got rdy=%b low=%0d expected 1 %0d", n, in_ready, low, NS + 1 + hold);
         end
      end
      checks++;
      if (ops_done !== 16'd200) begin
         errors++; $display("FAIL rand_ops_done: got %0d expected 200", ops_done);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_carry_ripple();
      test_order_backpressure();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
